// File: rtl/single_predict_pkg.sv
// Shared types and helpers for the single-precision MLP inference sequencer.
package single_predict_pkg;

  typedef enum logic [2:0] {
    IDLE,
    L1_ISSUE,
    L1_DRAIN,
    L2_ISSUE,
    L2_DRAIN,
    DONE
  } state_t;

  localparam int FP32_SIGN = 31;

  // Maps an FP32 bit pattern onto an unsigned key that orders like the float value.
  // Negatives invert completely and positives flip the sign bit.
  // As a result -0.0 sorts just below +0.0.
  function automatic logic [31:0] float_key(input logic [31:0] f);
    return f[FP32_SIGN] ? ~f : (f ^ 32'h8000_0000);
  endfunction

endpackage

// File: rtl/single_predict_seq_argmax.sv
// Running argmax over FP32 outputs; the first write is taken unconditionally and ties keep the lowest index.
module float_argmax
  import single_predict_pkg::*;
#(
  parameter int OW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          we,
  input  logic [OW-1:0] idx,
  input  logic [31:0]   data,
  output logic [OW-1:0] best_idx
);

  logic          r_have;
  logic [31:0]   r_key;
  logic [OW-1:0] r_idx;
  logic [31:0]   w_key;

  assign w_key    = float_key(data);
  assign best_idx = r_idx;

  // Track the best key seen since the last clear; only a strictly greater key replaces it.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_have <= 1'b0;
      r_key  <= '0;
      r_idx  <= '0;
    end else if (we && (!r_have || (w_key > r_key))) begin
      r_have <= 1'b1;
      r_key  <= w_key;
      r_idx  <= idx;
    end
  end

endmodule

// File: rtl/single_predict_seq.sv
// Two-layer MLP sequencer: issues one MAC op per weight, collects results in order, ReLUs the hidden layer, argmaxes the output layer.
module single_predict_seq
  import single_predict_pkg::*;
#(
  parameter  int LAYER1_NEURONS = 784,
  parameter  int LAYER2_NEURONS = 50,
  parameter  int OUTPUT_NODES   = 10,
  localparam int IW = $clog2(LAYER1_NEURONS),
  localparam int HW = $clog2(LAYER2_NEURONS),
  localparam int OW = $clog2(OUTPUT_NODES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          mac_valid,
  input  logic          mac_ready,
  output logic          mac_layer,
  output logic [IW-1:0] mac_in,
  output logic [HW-1:0] mac_neu,
  output logic          mac_first,
  output logic          mac_last,
  input  logic          res_valid,
  input  logic [31:0]   res_data,
  output logic          h_we,
  output logic [HW-1:0] h_addr,
  output logic [31:0]   h_data,
  output logic          y_we,
  output logic [OW-1:0] y_addr,
  output logic [31:0]   y_data,
  output logic [OW-1:0] class_idx,
  output logic          err
);

  localparam logic [IW-1:0] L1_IN_MAX  = IW'(LAYER1_NEURONS - 1);
  localparam logic [IW-1:0] L2_IN_MAX  = IW'(LAYER2_NEURONS - 1);
  localparam logic [HW-1:0] L1_NEU_MAX = HW'(LAYER2_NEURONS - 1);
  localparam logic [HW-1:0] L2_NEU_MAX = HW'(OUTPUT_NODES - 1);
  localparam logic [OW-1:0] Y_LAST     = OW'(OUTPUT_NODES - 1);

  state_t        r_state;
  logic          r_busy, r_done, r_err;
  logic          r_mac_valid, r_mac_layer, r_first, r_last;
  logic [IW-1:0] r_i;
  logic [HW-1:0] r_j, r_rcnt, r_h_addr;
  logic [HW:0]   r_out;
  logic          r_h_we, r_y_we;
  logic [OW-1:0] r_y_addr;
  logic [31:0]   r_h_data, r_y_data;

  logic          w_xfer, w_start_acc, w_inc, w_res_ok, w_in_l1;
  logic [IW-1:0] w_i_nxt, w_in_max;
  logic [HW-1:0] w_neu_max;

  assign w_xfer      = r_mac_valid & mac_ready;
  assign w_start_acc = (r_state == IDLE) & start;
  assign w_inc       = w_xfer & r_last;
  assign w_res_ok    = res_valid & (r_out != '0);
  assign w_in_l1     = (r_state == L1_ISSUE) | (r_state == L1_DRAIN);
  assign w_i_nxt     = r_i + IW'(1);
  assign w_in_max    = r_mac_layer ? L2_IN_MAX  : L1_IN_MAX;
  assign w_neu_max   = r_mac_layer ? L2_NEU_MAX : L1_NEU_MAX;

  // Sequencer FSM: op issue, result write-back, outstanding tracking and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_mac_valid <= 1'b0;
      r_mac_layer <= 1'b0;
      r_first     <= 1'b0;
      r_last      <= 1'b0;
      r_i         <= '0;
      r_j         <= '0;
      r_rcnt      <= '0;
      r_out       <= '0;
      r_h_we      <= 1'b0;
      r_h_addr    <= '0;
      r_h_data    <= '0;
      r_y_we      <= 1'b0;
      r_y_addr    <= '0;
      r_y_data    <= '0;
    end else begin
      r_h_we <= 1'b0;
      r_y_we <= 1'b0;
      r_done <= 1'b0;
      r_out  <= r_out + (HW+1)'(w_inc) - (HW+1)'(w_res_ok);

      // A result with nothing outstanding is stray; flag it and drop the data.
      if (res_valid && !w_res_ok) r_err <= 1'b1;
      if (w_res_ok) begin
        r_rcnt <= r_rcnt + HW'(1);
        if (w_in_l1) begin
          r_h_we   <= 1'b1;
          r_h_addr <= r_rcnt;
          r_h_data <= res_data[FP32_SIGN] ? 32'h0 : res_data;
        end else begin
          r_y_we   <= 1'b1;
          r_y_addr <= r_rcnt[OW-1:0];
          r_y_data <= res_data;
        end
      end

      case (r_state)
        IDLE: if (start) begin
          r_state     <= L1_ISSUE;
          r_busy      <= 1'b1;
          r_err       <= 1'b0;
          r_mac_valid <= 1'b1;
          r_mac_layer <= 1'b0;
          r_i         <= '0;
          r_j         <= '0;
          r_first     <= 1'b1;
          r_last      <= (L1_IN_MAX == '0);
          r_rcnt      <= '0;
        end
        L1_ISSUE, L2_ISSUE: if (w_xfer) begin
          if (r_last && (r_j == w_neu_max)) begin
            r_mac_valid <= 1'b0;
            r_first     <= 1'b0;
            r_last      <= 1'b0;
            r_i         <= '0;
            r_j         <= '0;
            r_state     <= (r_state == L1_ISSUE) ? L1_DRAIN : L2_DRAIN;
          end else if (r_last) begin
            r_i     <= '0;
            r_j     <= r_j + HW'(1);
            r_first <= 1'b1;
            r_last  <= (w_in_max == '0);
          end else begin
            r_i     <= w_i_nxt;
            r_first <= 1'b0;
            r_last  <= (w_i_nxt == w_in_max);
          end
        end
        // Layer 2 starts only once the final hidden write has been presented.
        L1_DRAIN: if (r_h_we && (r_h_addr == L1_NEU_MAX)) begin
          r_state     <= L2_ISSUE;
          r_mac_valid <= 1'b1;
          r_mac_layer <= 1'b1;
          r_i         <= '0;
          r_j         <= '0;
          r_first     <= 1'b1;
          r_last      <= (L2_IN_MAX == '0);
          r_rcnt      <= '0;
        end
        L2_DRAIN: if (r_y_we && (r_y_addr == Y_LAST)) begin
          r_state <= DONE;
          r_done  <= 1'b1;
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  float_argmax #(.OW(OW)) u_argmax (
    .clk      (clk),
    .rst      (rst),
    .clr      (w_start_acc),
    .we       (r_y_we),
    .idx      (r_y_addr),
    .data     (r_y_data),
    .best_idx (class_idx)
  );

  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign mac_valid = r_mac_valid;
  assign mac_layer = r_mac_layer;
  assign mac_in    = r_i;
  assign mac_neu   = r_j;
  assign mac_first = r_first;
  assign mac_last  = r_last;
  assign h_we      = r_h_we;
  assign h_addr    = r_h_addr;
  assign h_data    = r_h_data;
  assign y_we      = r_y_we;
  assign y_addr    = r_y_addr;
  assign y_data    = r_y_data;

endmodule

// File: tb/tb_single_predict_seq.sv
// Scoreboard bench for single_predict_seq at 4-3-2 with a 3-cycle MAC model.
module tb_single_predict_seq;
  localparam int IW = 2, HW = 2, OW = 1;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, mac_ready = 1'b1, res_valid = 1'b0;
  logic [31:0] res_data = '0;
  logic busy, done, mac_valid, mac_layer, mac_first, mac_last, h_we, y_we, err;
  logic [IW-1:0] mac_in;
  logic [HW-1:0] mac_neu, h_addr;
  logic [OW-1:0] y_addr, class_idx;
  logic [31:0] h_data, y_data;

  always #5 clk = ~clk;

  single_predict_seq #(.LAYER1_NEURONS(4), .LAYER2_NEURONS(3), .OUTPUT_NODES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mac_valid(mac_valid), .mac_ready(mac_ready), .mac_layer(mac_layer),
    .mac_in(mac_in), .mac_neu(mac_neu), .mac_first(mac_first), .mac_last(mac_last),
    .res_valid(res_valid), .res_data(res_data),
    .h_we(h_we), .h_addr(h_addr), .h_data(h_data),
    .y_we(y_we), .y_addr(y_addr), .y_data(y_data),
    .class_idx(class_idx), .err(err));

  logic [95:0] allout;
  assign allout = 96'({busy, done, mac_valid, mac_layer, mac_in, mac_neu, mac_first, mac_last,
                       h_we, h_addr, h_data, y_we, y_addr, y_data, class_idx, err});

  typedef struct packed {
    logic          layer;
    logic [IW-1:0] in;
    logic [HW-1:0] neu;
    logic          first;
    logic          last;
  } op_t;
  typedef struct packed {
    logic [1:0]  addr;
    logic [31:0] data;
  } wr_t;

  op_t exp_op[$];
  wr_t exp_h[$], exp_y[$];
  int  exp_cls[$];

  int errors = 0, checks = 0;
  int cyc = 0, last_y = 0, hcnt = 0, ndone = 0, rmode = 0;
  logic [31:0] l1v[3], l2v[2];
  logic xl = 1'b0, inj = 1'b0, tog = 1'b0;
  logic [31:0] xd = '0, inj_data = '0;
  logic pv[3];
  logic [31:0] pd[3];

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: event with no expectation at cycle %0d", nm, cyc);
  endtask

  // MAC model and ready/result drivers, updated just after each rising edge.
  initial begin
    for (int k = 0; k < 3; k++) begin pv[k] = 1'b0; pd[k] = '0; end
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        for (int k = 0; k < 3; k++) pv[k] = 1'b0;
      end else begin
        pv[2] = pv[1]; pd[2] = pd[1];
        pv[1] = pv[0]; pd[1] = pd[0];
        pv[0] = xl;    pd[0] = xd;
      end
      xl = 1'b0;
      res_valid = pv[2] | inj;
      res_data  = inj ? inj_data : pd[2];
      tog = ~tog;
      mac_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? tog : 1'($urandom_range(0, 1));
    end
  end

  // Monitor: sampled on the falling edge, pops expectations as the DUT presents them.
  op_t cur, prev_op, e;
  logic prev_stall = 1'b0;
  wr_t w;
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        cur = '{layer: mac_layer, in: mac_in, neu: mac_neu, first: mac_first, last: mac_last};
        if (prev_stall) chk("mac_hold", 96'({mac_valid, cur}), 96'({1'b1, prev_op}));
        if (mac_valid && mac_ready) begin
          if (exp_op.size() == 0) fail("op_extra");
          else begin e = exp_op.pop_front(); chk("op_seq", 96'(cur), 96'(e)); end
          if (mac_layer && mac_first && mac_neu == 0) chk("l2_after_h", 96'(hcnt), 96'(3));
          if (mac_last) begin
            xl = 1'b1;
            xd = mac_layer ? l2v[mac_neu[0]] : l1v[mac_neu];
          end
        end
        prev_stall = mac_valid && !mac_ready;
        prev_op    = cur;
        if (h_we) begin
          hcnt++;
          if (exp_h.size() == 0) fail("h_extra");
          else begin w = exp_h.pop_front(); chk("h_write", 96'({h_addr, h_data}), 96'(w)); end
        end
        if (y_we) begin
          last_y = cyc;
          if (exp_y.size() == 0) fail("y_extra");
          else begin w = exp_y.pop_front(); chk("y_write", 96'({1'b0, y_addr, y_data}), 96'(w)); end
        end
        if (done) begin
          ndone++;
          chk("done_lat", 96'(cyc - last_y), 96'(1));
          chk("done_busy", 96'(busy), 96'(1));
          if (exp_cls.size() == 0) fail("done_extra");
          else chk("class_idx", 96'(class_idx), 96'(exp_cls.pop_front()));
        end
      end
    end
  end

  task automatic push_exp(input logic [31:0] a0, a1, a2, h0, h1, h2, b0, b1, input int cls);
    l1v[0] = a0; l1v[1] = a1; l1v[2] = a2;
    l2v[0] = b0; l2v[1] = b1;
    for (int j = 0; j < 3; j++)
      for (int i = 0; i < 4; i++)
        exp_op.push_back('{layer: 1'b0, in: IW'(i), neu: HW'(j), first: (i == 0), last: (i == 3)});
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < 3; i++)
        exp_op.push_back('{layer: 1'b1, in: IW'(i), neu: HW'(j), first: (i == 0), last: (i == 2)});
    exp_h.push_back('{addr: 2'd0, data: h0});
    exp_h.push_back('{addr: 2'd1, data: h1});
    exp_h.push_back('{addr: 2'd2, data: h2});
    exp_y.push_back('{addr: 2'd0, data: b0});
    exp_y.push_back('{addr: 2'd1, data: b1});
    exp_cls.push_back(cls);
    hcnt = 0;
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("start_busy_err", 96'({busy, err}), 96'({1'b1, 1'b0}));
  endtask

  task automatic run(input int mode, input logic [31:0] a0, a1, a2, h0, h1, h2, b0, b1,
                     input int cls, input bit pulse_l2);
    int d0;
    bit seen;
    rmode = mode;
    push_exp(a0, a1, a2, h0, h1, h2, b0, b1, cls);
    d0 = ndone;
    do_start();
    if (pulse_l2) begin
      seen = 0;
      for (int k = 0; k < 500 && !seen; k++) begin
        @(negedge clk);
        if (mac_valid && mac_layer) seen = 1;
      end
      if (!seen) fail("l2_wait_timeout");
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    for (int k = 0; k < 2000 && ndone == d0; k++) @(negedge clk);
    if (ndone == d0) fail("done_timeout");
    @(negedge clk);
    chk("busy_drop", 96'({busy, done}), 96'(0));
    chk("drained", 96'({exp_op.size(), exp_h.size(), exp_y.size()}), 96'(0));
    repeat (4) @(negedge clk);
  endtask

  initial begin
    bit seen;
    repeat (3) @(negedge clk);
    chk("reset_outs", allout, 96'(0));
    rst = 1'b0;

    // ReLU of -1.0/-0.0/+1.0; argmax of {-2.0,-1.0} -> 1
    run(0, 32'hBF800000, 32'h80000000, 32'h3F800000, 32'h0, 32'h0, 32'h3F800000,
        32'hC0000000, 32'hBF800000, 1, 0);
    // alternating stall; tie at 2.0 keeps index 0
    run(1, 32'h40400000, 32'h00000000, 32'hC0400000, 32'h40400000, 32'h0, 32'h0,
        32'h40000000, 32'h40000000, 0, 0);
    // random stall; +0.0 beats -0.0
    run(2, 32'h3F800000, 32'h3F800000, 32'h7F800000, 32'h3F800000, 32'h3F800000, 32'h7F800000,
        32'h80000000, 32'h00000000, 1, 0);

    // reset in the middle of layer 1 at j=1, i=2
    rmode = 0;
    push_exp(32'hBF800000, 32'h80000000, 32'h3F800000, 32'h0, 32'h0, 32'h3F800000,
             32'hC0000000, 32'hBF800000, 1);
    do_start();
    seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (mac_valid && !mac_layer && mac_neu == 1 && mac_in == 2) seen = 1;
    end
    if (!seen) fail("mid_l1_timeout");
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_outs", allout, 96'(0));
    exp_op.delete(); exp_h.delete(); exp_y.delete(); exp_cls.delete();
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // full run after reset, with a start pulse during layer 2 that must be ignored
    run(0, 32'hBF800000, 32'h80000000, 32'h3F800000, 32'h0, 32'h0, 32'h3F800000,
        32'hC0000000, 32'hBF800000, 1, 1);

    // stray result in IDLE sets sticky err
    chk("err_idle_before", 96'(err), 96'(0));
    inj_data = 32'h12345678; inj = 1'b1;
    @(negedge clk); inj = 1'b0;
    @(negedge clk);
    chk("err_set", 96'(err), 96'(1));
    repeat (5) @(negedge clk);
    chk("err_sticky", 96'({err, busy, h_we, y_we}), 96'({1'b1, 1'b0, 1'b0, 1'b0}));

    // next start clears err and runs normally
    run(2, 32'h40400000, 32'h00000000, 32'hC0400000, 32'h40400000, 32'h0, 32'h0,
        32'h40000000, 32'h40000000, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
